if_fetch_buf: RTL and testbench

- Instruction-fetch front end sitting directly upstream and downstream of the core instruction RAM.
- Generates the next-fetch address and read enable into the RAM, and captures the returned PC/instruction pair one cycle later into a small FIFO.
- Presents a valid/ready instruction stream to the decode stage.
- Handles decode back-pressure and branch/jump redirects without losing or duplicating instructions.

---
 rtl/if_fetch_buf_pkg.sv | 23 ++
 rtl/if_fifo.sv | 57 +++++
 rtl/if_fetch_buf.sv | 91 +++++++++
 tb/tb_if_fetch_buf.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_buf_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// The address/instruction widths and reset PC must match the instruction RAM.
package if_fetch_buf_pkg;

    localparam int InstBus     = 32;
    localparam int InstAddrBus = 32;

    localparam logic [InstAddrBus-1:0] RstPC   = 32'h0800_0000;
    localparam logic [InstBus-1:0]     NopInst = 32'h0000_0013;  // addi x0, x0, 0

    typedef struct packed {
        logic [InstAddrBus-1:0] pc;
        logic [InstBus-1:0]     inst;
    } fetch_entry_t;

    localparam int EntryW = $bits(fetch_entry_t);

    // Redirect targets are always word aligned; low bits are dropped, not trapped.
    function automatic logic [InstAddrBus-1:0] align_word(input logic [InstAddrBus-1:0] addr);
        return {addr[InstAddrBus-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO with synchronous clear and an occupancy count.
// Head is a plain register read; there is no write-to-read bypass.
module if_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset so the head reads 0 out of reset; this is
            // only affordable because the FIFO is a handful of flops, not a RAM.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Push and pop together leave the count alone, even when full.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_buf.sv
// Instruction-fetch front end: drives the instruction RAM address/read enable,
// buffers returned {pc, inst} pairs and presents them to decode as valid/ready.
module if_fetch_buf
    import if_fetch_buf_pkg::*;
#(
    parameter logic [InstAddrBus-1:0] RST_PC    = RstPC,
    parameter int                     BUF_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [InstAddrBus-1:0] pc_n_o,
    output logic                   iram_rd_o,
    input  logic                   iram_rstn_i,
    input  logic [InstAddrBus-1:0] pc_i,
    input  logic [InstBus-1:0]     inst_i,
    input  logic                   jump_en_i,
    input  logic [InstAddrBus-1:0] jump_addr_i,
    output logic                   id_valid_o,
    input  logic                   id_ready_i,
    output logic [InstAddrBus-1:0] id_pc_o,
    output logic [InstBus-1:0]     id_inst_o
);

    localparam int         CW        = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(BUF_DEPTH);

    logic [InstAddrBus-1:0] fetch_pc;
    logic                   inflight;
    logic [CW-1:0]          fifo_count;
    logic                   pop;
    logic                   capture;
    logic                   issue;
    logic [CW:0]            occupancy;
    fetch_entry_t           wr_entry;
    fetch_entry_t           head_entry;

    assign pop     = id_valid_o & id_ready_i;
    assign capture = inflight & ~jump_en_i;

    // Slots that will be committed after this edge; pop can only be 1 when the
    // FIFO is non-empty, so the subtraction never wraps.
    assign occupancy = {1'b0, fifo_count}
                     + {{CW{1'b0}}, inflight}
                     - {{CW{1'b0}}, pop};

    // A redirect always issues: the flush frees the whole buffer this edge.
    assign issue     = jump_en_i | (occupancy < DEPTH_LIM);
    assign iram_rd_o = issue;
    assign pc_n_o    = jump_en_i ? align_word(jump_addr_i) : fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RST_PC;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= pc_n_o + 32'd4;
            end
        end
    end

    assign wr_entry.pc   = pc_i;
    assign wr_entry.inst = inst_i;

    // Decode flushes itself on a redirect, so its pop that cycle is dropped.
    if_fifo #(
        .WIDTH (EntryW),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (jump_en_i),
        .push  (capture),
        .pop   (pop & ~jump_en_i),
        .din   (wr_entry),
        .head  (head_entry),
        .count (fifo_count)
    );

    assign id_valid_o = (fifo_count != '0);
    assign id_pc_o    = head_entry.pc;
    assign id_inst_o  = head_entry.inst;

    // The RAM fetches RST_PC by itself in its reset-exit cycle; we must agree.
    rst_fetch_pc_a : assert property (
        @(posedge clk) disable iff (!rst_n)
        iram_rstn_i |-> (iram_rd_o && pc_n_o == RST_PC)
    );

endmodule

// File: tb/tb_if_fetch_buf.sv
// Self-checking bench for if_fetch_buf: a 1-cycle RAM model plus a scoreboard
// of issued fetch addresses that must reach decode in order, minus flushed ones.
module tb_if_fetch_buf;

    localparam logic [31:0] RST     = 32'h0800_0000;
    localparam logic [31:0] KEY     = 32'hA5A5_A5A5;
    localparam int          BUF_DEP = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_n_o;
    logic        iram_rd_o;
    logic        iram_rstn_i;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] sb_q[$];
    logic [31:0] seq_pc;

    if_fetch_buf #(
        .RST_PC    (RST),
        .BUF_DEPTH (BUF_DEP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_n_o      (pc_n_o),
        .iram_rd_o   (iram_rd_o),
        .iram_rstn_i (iram_rstn_i),
        .pc_i        (pc_i),
        .inst_i      (inst_i),
        .jump_en_i   (jump_en_i),
        .jump_addr_i (jump_addr_i),
        .id_valid_o  (id_valid_o),
        .id_ready_i  (id_ready_i),
        .id_pc_o     (id_pc_o),
        .id_inst_o   (id_inst_o)
    );

    always #5 clk = ~clk;

    // Instruction RAM: one-cycle read latency, data = address ^ KEY.
    initial begin
        pc_i   = '0;
        inst_i = '0;
    end
    always @(posedge clk) begin
        if (iram_rd_o) begin
            pc_i   <= pc_n_o;
            inst_i <= pc_n_o ^ KEY;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs, let the combinational outputs settle, then
    // check the fetch address and the decode head against the scoreboard.
    task automatic drive_and_check(input logic rdy, input logic jmp,
                                   input logic [31:0] jaddr, input logic rstn_pulse);
        logic [31:0] exp_pc;
        id_ready_i  = rdy;
        jump_en_i   = jmp;
        jump_addr_i = jaddr;
        iram_rstn_i = rstn_pulse;
        #1;
        check("no_overflow",
              32'(dut.capture && int'(dut.fifo_count) == BUF_DEP && !dut.pop), 32'd0);
        if (id_valid_o && rdy && !jmp) begin
            if (sb_q.size() == 0) begin
                check("sb_underrun", 32'(id_valid_o), 32'd0);
            end else begin
                exp_pc = sb_q.pop_front();
                check("id_pc", id_pc_o, exp_pc);
                check("id_inst", id_inst_o, exp_pc ^ KEY);
            end
        end
        if (jmp) begin
            check("jump_rd", 32'(iram_rd_o), 32'd1);
            sb_q.delete();
            seq_pc = {jaddr[31:2], 2'b00};
        end
        if (iram_rd_o) begin
            check("pc_n", pc_n_o, seq_pc);
            sb_q.push_back(seq_pc);
            seq_pc = seq_pc + 32'd4;
        end else begin
            check("pc_hold", pc_n_o, seq_pc);
        end
        check("occupancy", 32'(sb_q.size() <= BUF_DEP), 32'd1);
    endtask

    task automatic cycle(input logic rdy, input logic jmp, input logic [31:0] jaddr);
        @(posedge clk);
        #1;
        drive_and_check(rdy, jmp, jaddr, 1'b0);
    endtask

    // Reset-exit cycle: the RAM's own reset fetch coincides with ours.
    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        seq_pc = RST;
        sb_q.delete();
        drive_and_check(1'b1, 1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        rst_n       = 1'b0;
        id_ready_i  = 1'b0;
        jump_en_i   = 1'b0;
        jump_addr_i = '0;
        iram_rstn_i = 1'b0;
        seq_pc      = RST;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(id_valid_o), 32'd0);
        check("rst_pc_n", pc_n_o, RST);
        check("rst_rd", 32'(iram_rd_o), 32'd1);
        check("rst_id_pc", id_pc_o, 32'd0);
        check("rst_id_inst", id_inst_o, 32'd0);

        // Reset exit and steady stream: first instruction at cycle 2.
        release_reset();
        cycle(1'b1, 1'b0, 32'd0);
        check("c1_valid", 32'(id_valid_o), 32'd0);
        check("c1_pc_n", pc_n_o, RST + 32'd4);
        cycle(1'b1, 1'b0, 32'd0);
        check("c2_valid", 32'(id_valid_o), 32'd1);
        check("c2_pc", id_pc_o, RST);
        repeat (8) begin
            cycle(1'b1, 1'b0, 32'd0);
            check("stream_valid", 32'(id_valid_o), 32'd1);
            check("stream_rd", 32'(iram_rd_o), 32'd1);
        end

        // Decode back-pressure: buffer fills, fetch stops, then drains in order.
        repeat (6) cycle(1'b0, 1'b0, 32'd0);
        check("bp_rd", 32'(iram_rd_o), 32'd0);
        check("bp_valid", 32'(id_valid_o), 32'd1);
        check("bp_entries", sb_q.size(), 32'd2);
        repeat (6) cycle(1'b1, 1'b0, 32'd0);

        // Redirect during a flowing stream.
        cycle(1'b1, 1'b1, 32'h0000_0100);
        check("j_pc_n", pc_n_o, 32'h0000_0100);
        cycle(1'b1, 1'b0, 32'd0);
        check("j_flushed", 32'(id_valid_o), 32'd0);
        cycle(1'b1, 1'b0, 32'd0);
        check("j_head0", id_pc_o, 32'h0000_0100);
        cycle(1'b1, 1'b0, 32'd0);
        check("j_head1", id_pc_o, 32'h0000_0104);

        // Redirect with the buffer full and decode stalled.
        repeat (4) cycle(1'b0, 1'b0, 32'd0);
        check("jf_pre_rd", 32'(iram_rd_o), 32'd0);
        cycle(1'b0, 1'b1, 32'h0000_0100);
        check("jf_pc_n", pc_n_o, 32'h0000_0100);
        cycle(1'b0, 1'b0, 32'd0);
        check("jf_flushed", 32'(id_valid_o), 32'd0);
        repeat (4) begin
            cycle(1'b0, 1'b0, 32'd0);
            check("jf_valid", 32'(id_valid_o), 32'd1);
            check("jf_head", id_pc_o, 32'h0000_0100);
        end
        repeat (4) cycle(1'b1, 1'b0, 32'd0);

        // Misaligned redirect target.
        cycle(1'b1, 1'b1, 32'h0000_0206);
        check("mis_pc_n", pc_n_o, 32'h0000_0204);
        cycle(1'b1, 1'b0, 32'd0);
        check("mis_next", pc_n_o, 32'h0000_0208);
        repeat (3) cycle(1'b1, 1'b0, 32'd0);

        // Address wrap at the top of the address space.
        cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
        check("wrap0", pc_n_o, 32'hFFFF_FFF8);
        cycle(1'b1, 1'b0, 32'd0);
        check("wrap1", pc_n_o, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 32'd0);
        check("wrap2", pc_n_o, 32'h0000_0000);
        check("wrap2_rd", 32'(iram_rd_o), 32'd1);
        repeat (4) cycle(1'b1, 1'b0, 32'd0);

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(id_valid_o), 32'd0);
        check("mid_rst_pc_n", pc_n_o, RST);
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_id_pc", id_pc_o, 32'd0);
        release_reset();
        cycle(1'b1, 1'b0, 32'd0);
        check("re_c1_valid", 32'(id_valid_o), 32'd0);
        cycle(1'b1, 1'b0, 32'd0);
        check("re_c2_valid", 32'(id_valid_o), 32'd1);
        check("re_c2_pc", id_pc_o, RST);
        repeat (4) cycle(1'b1, 1'b0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
